// File: rtl/wt_dcache_mem_mb.sv
// Write-through data cache memory: banked data arrays, per-way tag arrays,
// resettable valid bits, multi-port read arbitration and a line-fill FSM.
module wt_dcache_mem_mb #(
    parameter int unsigned NumPorts  = 3,
    parameter int unsigned NumWays   = 4,
    parameter int unsigned NumSets   = 256,
    parameter int unsigned LineWidth = 128,
    parameter int unsigned WordWidth = 64,
    parameter int unsigned TagWidth  = 44,
    parameter int unsigned BeatWidth = 64,
    localparam int unsigned IW = $clog2(NumSets),
    localparam int unsigned OW = $clog2(LineWidth / 8),
    localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumPorts-1:0]          rd_req_i,
    input  logic [NumPorts-1:0]          rd_prio_i,
    input  logic [NumPorts-1:0]          rd_tag_only_i,
    input  logic [NumPorts*IW-1:0]       rd_idx_i,
    input  logic [NumPorts*OW-1:0]       rd_off_i,
    input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
    output logic [NumPorts-1:0]          rd_gnt_o,
    output logic                         rd_rvalid_o,
    output logic [PW-1:0]                rd_port_o,
    output logic [NumWays-1:0]           rd_hit_oh_o,
    output logic [NumWays-1:0]           rd_vld_bits_o,
    output logic [WordWidth-1:0]         rd_data_o,
    input  logic                         fill_valid_i,
    output logic                         fill_ready_o,
    input  logic [NumWays-1:0]           fill_way_oh_i,
    input  logic [IW-1:0]                fill_idx_i,
    input  logic [TagWidth-1:0]          fill_tag_i,
    input  logic [BeatWidth-1:0]         fill_data_i,
    output logic                         fill_done_o,
    input  logic [NumWays-1:0]           wr_req_i,
    input  logic [IW-1:0]                wr_idx_i,
    input  logic [OW-1:0]                wr_off_i,
    input  logic [WordWidth-1:0]         wr_data_i,
    input  logic [WordWidth/8-1:0]       wr_be_i,
    output logic                         wr_ack_o,
    input  logic                         inv_req_i,
    input  logic [IW-1:0]                inv_idx_i,
    input  logic [NumWays-1:0]           inv_way_oh_i,
    output logic                         inv_ack_o,
    input  logic                         flush_i
);

    localparam int unsigned NB  = LineWidth / WordWidth;
    localparam int unsigned BPL = LineWidth / BeatWidth;
    localparam int unsigned WOB = $clog2(WordWidth / 8);
    localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int unsigned BEW = WordWidth / 8;

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} fill_state_e;

    // bank holding the word addressed by a byte offset
    function automatic logic [BW-1:0] bank_of(input logic [OW-1:0] off);
        return BW'(off >> WOB);
    endfunction

    // round-robin pointer arithmetic modulo NumPorts
    function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NumPorts) s = s - NumPorts;
        return PW'(s);
    endfunction

    fill_state_e                    state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           beat_acc;
    logic                           commit;
    logic [NumWays-1:0]             f_way_q;
    logic [IW-1:0]                  f_idx_q;
    logic [TagWidth-1:0]            f_tag_q;
    logic [LineWidth-1:0]           line_q;

    logic [NumSets-1:0][NumWays-1:0] valid_q;
    logic [WordWidth-1:0]           data_mem [NB][NumWays][NumSets];
    logic [TagWidth-1:0]            tag_mem  [NumWays][NumSets];

    logic [PW-1:0]                  rr_q;
    logic [NumPorts-1:0]            hp, elig;
    logic [PW-1:0]                  cand, gidx;
    logic                           gnt_any, blocked;
    logic [IW-1:0]                  rd_idx_sel;
    logic [OW-1:0]                  rd_off_sel;
    logic                           tag_only_sel;

    logic                           rvalid_q, tag_only_q;
    logic [PW-1:0]                  port_q;
    logic [BW-1:0]                  bank_q;
    logic [NumWays-1:0]             vld_bits_q;
    logic [TagWidth-1:0]            tag_rd_q  [NumWays];
    logic [WordWidth-1:0]           data_rd_q [NB][NumWays];
    logic [TagWidth-1:0]            resp_tag;

    // fill FSM state register and beat counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // fill FSM next state: collect BPL beats, then one commit cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_ready_o = 1'b1;
        fill_done_o  = 1'b0;
        beat_acc     = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (fill_valid_i) begin
                    beat_acc = 1'b1;
                    if (cnt_q == CW'(BPL - 1)) begin
                        cnt_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = COLLECT;
                    end
                end
            end
            COMMIT: begin
                fill_ready_o = 1'b0;
                fill_done_o  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit = (state_q == COMMIT);

    // line buffer and fill target captured from incoming beats
    always_ff @(posedge clk_i) begin
        if (beat_acc) begin
            if (state_q == IDLE) begin
                f_way_q <= fill_way_oh_i;
                f_idx_q <= fill_idx_i;
                f_tag_q <= fill_tag_i;
            end
            line_q[32'(cnt_q)*BeatWidth +: BeatWidth] <= fill_data_i;
        end
    end

    assign inv_ack_o = inv_req_i & ~commit;
    assign blocked   = commit | inv_ack_o;

    // read arbiter: high-priority mask, then round-robin from rr_q
    always_comb begin
        rd_gnt_o = '0;
        gidx     = '0;
        gnt_any  = 1'b0;
        cand     = '0;
        hp       = rd_req_i & rd_prio_i;
        elig     = (|hp) ? hp : rd_req_i;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = rr_add(rr_q, i);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gidx    = cand;
            end
        end
        if (blocked) gnt_any = 1'b0;
        if (gnt_any) rd_gnt_o[gidx] = 1'b1;
    end

    assign rd_idx_sel   = rd_idx_i[32'(gidx)*IW +: IW];
    assign rd_off_sel   = rd_off_i[32'(gidx)*OW +: OW];
    assign tag_only_sel = rd_tag_only_i[gidx];

    // word writes yield to commits and to a granted data read of the same bank
    assign wr_ack_o = (|wr_req_i) & ~commit &
                      ~(gnt_any & ~tag_only_sel & (bank_of(rd_off_sel) == bank_of(wr_off_i)));

    // round-robin pointer advances past the granted port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_q <= '0;
        else if (gnt_any) rr_q <= rr_add(gidx, 1);
    end

    // valid bits: flush overrides commit set and invalidate clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            if (commit)    valid_q[f_idx_q]   <= valid_q[f_idx_q] | f_way_q;
            if (inv_ack_o) valid_q[inv_idx_i] <= valid_q[inv_idx_i] & ~inv_way_oh_i;
        end
    end

    // data banks and tag arrays: commit/word writes, synchronous read on grant
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int unsigned w = 0; w < NumWays; w++) begin
                if (f_way_q[w]) begin
                    tag_mem[w][f_idx_q] <= f_tag_q;
                    for (int unsigned b = 0; b < NB; b++)
                        data_mem[b][w][f_idx_q] <= line_q[b*WordWidth +: WordWidth];
                end
            end
        end else if (wr_ack_o) begin
            for (int unsigned w = 0; w < NumWays; w++) begin
                if (wr_req_i[w]) begin
                    for (int unsigned j = 0; j < BEW; j++)
                        if (wr_be_i[j])
                            data_mem[bank_of(wr_off_i)][w][wr_idx_i][j*8 +: 8] <= wr_data_i[j*8 +: 8];
                end
            end
        end
        if (gnt_any) begin
            for (int unsigned w = 0; w < NumWays; w++) begin
                tag_rd_q[w] <= tag_mem[w][rd_idx_sel];
                for (int unsigned b = 0; b < NB; b++)
                    data_rd_q[b][w] <= data_mem[b][w][rd_idx_sel];
            end
        end
    end

    // read response context; a flush in the grant cycle empties the snapshot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q   <= 1'b0;
            port_q     <= '0;
            tag_only_q <= 1'b0;
            bank_q     <= '0;
            vld_bits_q <= '0;
        end else begin
            rvalid_q <= gnt_any;
            if (gnt_any) begin
                port_q     <= gidx;
                tag_only_q <= tag_only_sel;
                bank_q     <= bank_of(rd_off_sel);
                vld_bits_q <= flush_i ? '0 : valid_q[rd_idx_sel];
            end
        end
    end

    // tag compare against the late tag of the responding port
    always_comb begin
        rd_hit_oh_o = '0;
        rd_data_o   = '0;
        resp_tag    = rd_tag_i[32'(port_q)*TagWidth +: TagWidth];
        for (int unsigned w = 0; w < NumWays; w++) begin
            rd_hit_oh_o[w] = rvalid_q & vld_bits_q[w] & (tag_rd_q[w] == resp_tag);
            if (rd_hit_oh_o[w] && !tag_only_q) rd_data_o = rd_data_o | data_rd_q[bank_q][w];
        end
    end

    assign rd_rvalid_o   = rvalid_q;
    assign rd_port_o     = port_q;
    assign rd_vld_bits_o = vld_bits_q;

endmodule

// File: tb/tb_wt_dcache_mem_mb.sv
// Randomized bench for wt_dcache_mem_mb against a line-level cache model.
module tb_wt_dcache_mem_mb;

    localparam int unsigned NP = 3, NW = 4, NS = 256, LW = 128, WW = 64, TW = 44, BTW = 64;
    localparam int unsigned IW = 8, OW = 4, PW = 2, BPL = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NP-1:0]     rd_req_i, rd_prio_i, rd_tag_only_i;
    logic [NP*IW-1:0]  rd_idx_i;
    logic [NP*OW-1:0]  rd_off_i;
    logic [NP*TW-1:0]  rd_tag_i;
    logic [NP-1:0]     rd_gnt_o;
    logic              rd_rvalid_o;
    logic [PW-1:0]     rd_port_o;
    logic [NW-1:0]     rd_hit_oh_o, rd_vld_bits_o;
    logic [WW-1:0]     rd_data_o;
    logic              fill_valid_i, fill_ready_o, fill_done_o;
    logic [NW-1:0]     fill_way_oh_i;
    logic [IW-1:0]     fill_idx_i;
    logic [TW-1:0]     fill_tag_i;
    logic [BTW-1:0]    fill_data_i;
    logic [NW-1:0]     wr_req_i;
    logic [IW-1:0]     wr_idx_i;
    logic [OW-1:0]     wr_off_i;
    logic [WW-1:0]     wr_data_i;
    logic [WW/8-1:0]   wr_be_i;
    logic              wr_ack_o;
    logic              inv_req_i;
    logic [IW-1:0]     inv_idx_i;
    logic [NW-1:0]     inv_way_oh_i;
    logic              inv_ack_o;
    logic              flush_i;

    wt_dcache_mem_mb dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_req_i(rd_req_i), .rd_prio_i(rd_prio_i), .rd_tag_only_i(rd_tag_only_i),
        .rd_idx_i(rd_idx_i), .rd_off_i(rd_off_i), .rd_tag_i(rd_tag_i),
        .rd_gnt_o(rd_gnt_o), .rd_rvalid_o(rd_rvalid_o), .rd_port_o(rd_port_o),
        .rd_hit_oh_o(rd_hit_oh_o), .rd_vld_bits_o(rd_vld_bits_o), .rd_data_o(rd_data_o),
        .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_way_oh_i(fill_way_oh_i),
        .fill_idx_i(fill_idx_i), .fill_tag_i(fill_tag_i), .fill_data_i(fill_data_i),
        .fill_done_o(fill_done_o),
        .wr_req_i(wr_req_i), .wr_idx_i(wr_idx_i), .wr_off_i(wr_off_i),
        .wr_data_i(wr_data_i), .wr_be_i(wr_be_i), .wr_ack_o(wr_ack_o),
        .inv_req_i(inv_req_i), .inv_idx_i(inv_idx_i), .inv_way_oh_i(inv_way_oh_i),
        .inv_ack_o(inv_ack_o), .flush_i(flush_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // model: whole lines per set/way, tags, valid bits, fill progress
    logic [LW-1:0] m_line [NS][NW];
    logic [TW-1:0] m_tag  [NS][NW];
    logic [NW-1:0] m_vld  [NS];
    int            m_rr, m_beats;
    bit            m_commit;
    logic [NW-1:0] f_way;
    int            f_idx;
    logic [TW-1:0] f_tag;
    logic [LW-1:0] f_line;

    // outstanding read: what the arrays held when it was granted
    bit            p_valid, p_to;
    int            p_port, p_idx, p_off;
    logic [NW-1:0] p_vld;
    logic [TW-1:0] p_tags  [NW];
    logic [LW-1:0] p_lines [NW];
    logic [TW-1:0] next_rd_tag;

    logic [NP-1:0] obs_gnt;
    logic [NW-1:0] obs_hit, obs_vld;
    logic [WW-1:0] obs_data;
    logic          obs_wack, obs_iack, obs_done;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rd_req_i = '0; rd_prio_i = '0; rd_tag_only_i = '0; rd_idx_i = '0; rd_off_i = '0;
        rd_tag_i = '0; fill_valid_i = 1'b0; fill_way_oh_i = '0; fill_idx_i = '0;
        fill_tag_i = '0; fill_data_i = '0; wr_req_i = '0; wr_idx_i = '0; wr_off_i = '0;
        wr_data_i = '0; wr_be_i = '0; inv_req_i = 1'b0; inv_idx_i = '0; inv_way_oh_i = '0;
        flush_i = 1'b0;
    endtask

    task automatic model_reset();
        m_commit = 0; m_beats = 0; m_rr = 0; p_valid = 0;
        for (int s = 0; s < NS; s++) m_vld[s] = '0;
    endtask

    // one clock cycle: check outputs against the model, then advance the model
    task automatic step();
        int            g, widx;
        logic [NP-1:0] hpm, cnd, e_gnt;
        logic [NW-1:0] e_hit;
        logic [WW-1:0] e_data;
        bit            e_wack, e_iack;
        rd_tag_i = '0;
        if (p_valid) rd_tag_i[p_port*TW +: TW] = next_rd_tag;
        #1;
        obs_gnt = rd_gnt_o; obs_hit = rd_hit_oh_o; obs_data = rd_data_o; obs_vld = rd_vld_bits_o;
        obs_wack = wr_ack_o; obs_iack = inv_ack_o; obs_done = fill_done_o;
        e_hit = '0; e_data = '0;
        if (p_valid) begin
            for (int w = 0; w < NW; w++) begin
                if (p_vld[w] && p_tags[w] == next_rd_tag) begin
                    e_hit[w] = 1'b1;
                    if (!p_to) e_data = p_lines[w][(p_off / 8) * WW +: WW];
                end
            end
        end
        check("rvalid", rd_rvalid_o, p_valid);
        check("hit_oh", rd_hit_oh_o, e_hit);
        check("rdata", rd_data_o, e_data);
        if (p_valid) begin
            check("rd_port", rd_port_o, p_port);
            check("vld_bits", rd_vld_bits_o, p_vld);
        end
        check("fill_done", fill_done_o, m_commit);
        check("fill_ready", fill_ready_o, !m_commit);
        g = -1;
        if (!m_commit && !inv_req_i) begin
            hpm = rd_req_i & rd_prio_i;
            cnd = (hpm != 0) ? hpm : rd_req_i;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_rr + k) % NP;
                if (g < 0 && cnd[p]) g = p;
            end
        end
        e_gnt = '0;
        if (g >= 0) e_gnt[g] = 1'b1;
        check("rd_gnt", rd_gnt_o, e_gnt);
        e_iack = inv_req_i && !m_commit;
        check("inv_ack", inv_ack_o, e_iack);
        e_wack = (wr_req_i != 0) && !m_commit &&
                 !(g >= 0 && !rd_tag_only_i[g] && (rd_off_i[g*OW +: OW] / 8) == (wr_off_i / 8));
        check("wr_ack", wr_ack_o, e_wack);
        @(posedge clk_i);
        p_valid = (g >= 0);
        if (g >= 0) begin
            p_port = g;
            p_idx  = rd_idx_i[g*IW +: IW];
            p_off  = rd_off_i[g*OW +: OW];
            p_to   = rd_tag_only_i[g];
            p_vld  = flush_i ? '0 : m_vld[p_idx];
            for (int w = 0; w < NW; w++) begin
                p_tags[w]  = m_tag[p_idx][w];
                p_lines[w] = m_line[p_idx][w];
            end
            m_rr = (g + 1) % NP;
        end
        if (m_commit) begin
            for (int w = 0; w < NW; w++)
                if (f_way[w]) begin
                    m_line[f_idx][w] = f_line;
                    m_tag[f_idx][w]  = f_tag;
                end
        end
        if (e_wack) begin
            widx = wr_idx_i;
            for (int w = 0; w < NW; w++)
                if (wr_req_i[w])
                    for (int j = 0; j < WW/8; j++)
                        if (wr_be_i[j])
                            m_line[widx][w][(wr_off_i / 8) * WW + j*8 +: 8] = wr_data_i[j*8 +: 8];
        end
        if (flush_i) begin
            for (int s = 0; s < NS; s++) m_vld[s] = '0;
        end else begin
            if (m_commit) m_vld[f_idx] = m_vld[f_idx] | f_way;
            if (e_iack) m_vld[inv_idx_i] = m_vld[inv_idx_i] & ~inv_way_oh_i;
        end
        if (m_commit) begin
            m_commit = 0;
        end else if (fill_valid_i) begin
            if (m_beats == 0) begin
                f_way = fill_way_oh_i; f_idx = fill_idx_i; f_tag = fill_tag_i;
            end
            f_line[m_beats*BTW +: BTW] = fill_data_i;
            m_beats++;
            if (m_beats == BPL) begin
                m_beats  = 0;
                m_commit = 1;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic start_fill(input logic [NW-1:0] way, input int idx, input logic [TW-1:0] tag);
        fill_valid_i = 1'b1; fill_way_oh_i = way; fill_idx_i = IW'(idx); fill_tag_i = tag;
    endtask

    initial begin
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_line[s][w] = '0;
                m_tag[s][w]  = '0;
            end
        next_rd_tag = '0;
        idle_inputs();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_gnt", rd_gnt_o, 0);
        check("rst_rvalid", rd_rvalid_o, 0);
        check("rst_fill_done", fill_done_o, 0);
        check("rst_fill_ready", fill_ready_o, 1);
        check("rst_wr_ack", wr_ack_o, 0);
        check("rst_inv_ack", inv_ack_o, 0);
        check("rst_hit", rd_hit_oh_o, 0);
        check("rst_data", rd_data_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // two-beat fill, then hit on word 1
        start_fill(4'b0010, 5, 44'h12);
        fill_data_i = 64'hA; step();
        fill_data_i = 64'hB; step();
        fill_valid_i = 1'b0; step();
        check("d_fill_done_c3", obs_done, 1);
        rd_req_i = 3'b001; rd_idx_i[0 +: IW] = 8'd5; rd_off_i[0 +: OW] = 4'd8; step();
        rd_req_i = '0; next_rd_tag = 44'h12; step();
        check("d_hit_way1", obs_hit, 4'b0010);
        check("d_data_B", obs_data, 64'hB);

        // priority then round robin
        rd_req_i = 3'b111; rd_prio_i = 3'b010;
        for (int p = 0; p < NP; p++) rd_idx_i[p*IW +: IW] = 8'd5;
        step();
        check("d_prio_gnt", obs_gnt, 3'b010);
        rd_prio_i = '0;
        step(); check("d_rr_gnt2", obs_gnt, 3'b100);
        step(); check("d_rr_gnt0", obs_gnt, 3'b001);
        step(); check("d_rr_gnt1", obs_gnt, 3'b010);
        rd_req_i = '0; step();

        // bank conflict between read and word write
        rd_req_i = 3'b001; rd_off_i = '0; wr_req_i = 4'b0001; wr_idx_i = 8'd5;
        wr_off_i = 4'd0; wr_data_i = 64'h1234; wr_be_i = 8'hFF; step();
        check("d_wr_conflict", obs_wack, 0);
        wr_off_i = 4'd8; step();
        check("d_wr_other_bank", obs_wack, 1);
        rd_req_i = '0; wr_req_i = '0; step();

        // read held off during commit
        start_fill(4'b0001, 6, 44'h21);
        fill_data_i = 64'h1; step();
        fill_data_i = 64'h2; step();
        fill_valid_i = 1'b0; rd_req_i = 3'b001; rd_idx_i[0 +: IW] = 8'd6; rd_off_i = '0; step();
        check("d_gnt_in_commit", obs_gnt, 0);
        step();
        check("d_gnt_after_commit", obs_gnt, 3'b001);
        rd_req_i = '0; next_rd_tag = 44'h21; step();
        check("d_hit_set6", obs_hit, 4'b0001);
        check("d_data_set6", obs_data, 64'h1);

        // invalidate then flush
        inv_req_i = 1'b1; inv_idx_i = 8'd5; inv_way_oh_i = 4'b0010; step();
        check("d_inv_ack", obs_iack, 1);
        inv_req_i = 1'b0; rd_req_i = 3'b001; rd_idx_i[0 +: IW] = 8'd5; rd_off_i[0 +: OW] = 4'd8; step();
        rd_req_i = '0; next_rd_tag = 44'h12; step();
        check("d_inv_hit", obs_hit, 4'b0000);
        check("d_inv_data", obs_data, 0);
        flush_i = 1'b1; step();
        flush_i = 1'b0; rd_req_i = 3'b001; rd_idx_i[0 +: IW] = 8'd6; step();
        rd_req_i = '0; next_rd_tag = 44'h21; step();
        check("d_flush_vld", obs_vld, 4'b0000);
        check("d_flush_hit", obs_hit, 4'b0000);

        // reset in the middle of a fill
        start_fill(4'b0100, 7, 44'h33);
        fill_data_i = 64'h5; step();
        rst_ni = 1'b0; fill_valid_i = 1'b0;
        #1;
        check("d_rst_mid_ready", fill_ready_o, 1);
        check("d_rst_mid_done", fill_done_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        start_fill(4'b0100, 7, 44'h33);
        fill_data_i = 64'h7; step();
        fill_data_i = 64'h8; step();
        fill_valid_i = 1'b0; step();
        check("d_refill_done", obs_done, 1);
        rd_req_i = 3'b001; rd_idx_i[0 +: IW] = 8'd7; rd_off_i[0 +: OW] = 4'd8; step();
        rd_req_i = '0; next_rd_tag = 44'h33; step();
        check("d_refill_hit", obs_hit, 4'b0100);
        check("d_refill_data", obs_data, 64'h8);

        // randomized traffic over a few sets
        for (int it = 0; it < 3000; it++) begin
            int wn;
            rd_req_i      = NP'($urandom);
            rd_prio_i     = ($urandom % 3 == 0) ? NP'($urandom) : '0;
            rd_tag_only_i = ($urandom % 4 == 0) ? NP'($urandom) : '0;
            for (int p = 0; p < NP; p++) begin
                rd_idx_i[p*IW +: IW] = IW'($urandom % 4);
                rd_off_i[p*OW +: OW] = OW'($urandom);
            end
            wn = $urandom % NW;
            fill_valid_i  = ($urandom % 2) == 0;
            fill_way_oh_i = NW'(1) << wn;
            fill_idx_i    = IW'($urandom % 4);
            fill_tag_i    = TW'(($urandom % 4) * 4 + wn);
            fill_data_i   = {$urandom, $urandom};
            wn = $urandom % NW;
            wr_req_i  = ($urandom % 4 == 0) ? (NW'(1) << wn) : '0;
            wr_idx_i  = IW'($urandom % 4);
            wr_off_i  = OW'($urandom);
            wr_data_i = {$urandom, $urandom};
            wr_be_i   = 8'($urandom);
            inv_req_i    = ($urandom % 10) == 0;
            inv_idx_i    = IW'($urandom % 4);
            inv_way_oh_i = NW'($urandom);
            flush_i      = ($urandom % 50) == 0;
            if (p_valid && ($urandom % 4) != 0) next_rd_tag = p_tags[$urandom % NW];
            else next_rd_tag = TW'($urandom % 16);
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
